uart_cntr: RTL and testbench
============================

UART_CNTR -- requirements
Module: uart_cntr

Interface
REQ-001 Parameter baudrate, default 9600, serial bit rate in bits/s.
REQ-002 Parameter clk_frec, default 100000000, clk frequency in Hz; bit period BIT_CYC = clk_frec/baudrate (integer division; 10416 at defaults).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 arstn  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  UART serial input, idle high, asynchronous to clk.
REQ-006 humidity  input  3x8 (packed [2:0][7:0])  humidity bytes to transmit.
REQ-007 temperature  input  3x8 (packed [2:0][7:0])  temperature bytes to transmit.
REQ-008 send_h_t  input  1  one-cycle request to transmit humidity and temperature.
REQ-009 time_reg  output  6x8 (packed [5:0][7:0])  last valid received time payload.
REQ-010 new_time  output  1  one-cycle pulse when time_reg is updated.
REQ-011 tx  output  1  UART serial output, idle high.

Function
REQ-012 Serial format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit BIT_CYC clocks.
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver SHALL detect a falling edge while idle, re-check rx low at BIT_CYC/2, then sample each data bit and the stop bit at successive BIT_CYC intervals (mid-bit).
REQ-015 Start bit high at mid-point SHALL be treated as a glitch; receiver returns to idle, no byte produced.
REQ-016 Stop bit sampled low SHALL discard the byte (framing error); receiver then waits for rx high before re-arming.
REQ-017 Receiver SHALL re-arm for the next start bit immediately after the stop-bit sample; back-to-back frames SHALL be received.
REQ-018 Frame parser states: WAIT_R, DATA, WAIT_T.
REQ-019 WAIT_R: byte 0x72 ('r') -> DATA with index 0; any other byte ignored.
REQ-020 DATA: each byte (any value, including 0x72/0x74) stored to shadow buffer; first byte -> slot 5, sixth byte -> slot 0; after the sixth byte -> WAIT_T.
REQ-021 WAIT_T: byte 0x74 ('t') -> copy shadow buffer to time_reg and pulse new_time high one cycle on the next clock; return to WAIT_R.
REQ-022 WAIT_T: any other byte -> discard frame, time_reg unchanged, no new_time, return to WAIT_R.
REQ-023 A discarded (framing-error) byte SHALL NOT advance the parser.
REQ-024 time_reg SHALL hold its value between valid frames.
REQ-025 On send_h_t high while transmitter idle, SHALL snapshot humidity and temperature in that cycle and transmit 6 bytes in order: humidity[2], humidity[1], humidity[0], temperature[2], temperature[1], temperature[0].
REQ-026 Start bit of first byte SHALL begin on tx within 2 clocks of send_h_t; bytes SHALL be back-to-back with no idle gap beyond the stop bit.
REQ-027 send_h_t while a transmission is in progress SHALL be ignored; input changes after snapshot SHALL not affect bytes sent.
REQ-028 Receiver and transmitter SHALL operate concurrently and independently.

Reset
REQ-029 While arstn asserted: tx=1, new_time=0, time_reg=0, parser in WAIT_R, receiver and transmitter idle, all counters 0, shadow buffer 0.
REQ-030 Reset asserted mid-byte or mid-frame SHALL abort reception/transmission immediately; tx returns high asynchronously.
REQ-031 After deassertion, logic SHALL wait for rx idle-high before detecting a start bit.

Verification
REQ-032 rx bytes 0x72,30,31,32,33,34,35,0x74 at 104 us/bit -> time_reg[5..0]=30,31,32,33,34,35, new_time single-cycle pulse after 't' stop bit.
REQ-033 Second frame 0x72,33..38,0x74 -> time_reg[5..0]=33..38, one new_time pulse; third frame 30..35 restores first value.
REQ-034 Frame 0x72,six bytes,0x41 -> time_reg unchanged, no new_time; following valid frame accepted.
REQ-035 humidity=01,02,03, temperature=11,12,13 (decimal), send_h_t pulse -> tx bytes 0x01,0x02,0x03,0x0B,0x0C,0x0D, 8N1, each bit 10416 clocks.
REQ-036 Second send_h_t pulse mid-transmission ignored; later pulse with 21,22,23,31,32,33 -> tx 0x15,0x16,0x17,0x1F,0x20,0x21.
REQ-037 arstn asserted during tx byte -> tx high immediately, time_reg=0; after release, new send_h_t transmits full 6-byte sequence.

Source files
------------

// File: rtl/uart_cntr.sv
// UART time-frame receiver ('r' + 6 bytes + 't') and 6-byte humidity/temperature
// transmitter, 8N1, sharing one clock but otherwise independent.
module uart_cntr #(
  parameter int unsigned baudrate = 9600,
  parameter int unsigned clk_frec = 100000000
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic            rx,
  input  logic [2:0][7:0] humidity,
  input  logic [2:0][7:0] temperature,
  input  logic            send_h_t,
  output logic [5:0][7:0] time_reg,
  output logic            new_time,
  output logic            tx
);

  localparam int unsigned BIT_CYC = clk_frec / baudrate;
  localparam int unsigned HALF    = BIT_CYC / 2;
  localparam int unsigned CW      = $clog2(BIT_CYC);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {RX_REARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_R, DATA, WAIT_T} p_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic            rx_meta, rx_sync;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_clr, rx_shift_en, byte_ok;

  p_state_t        p_state, p_next;
  logic [2:0]      p_idx;
  logic [5:0][7:0] shadow;
  logic            store, commit;

  tx_state_t       tx_state, tx_next;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit, tx_bit_n, tx_nb;
  logic [5:0][7:0] tx_buf;
  logic            tx_clr, tx_load, tx_adv, tx_byte_done, tx_d;

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver: REARM waits for the line to be high so a low line after reset
  // or a framing error is never taken as a start bit.
  always_comb begin
    rx_next     = rx_state;
    rx_clr      = 1'b0;
    rx_shift_en = 1'b0;
    byte_ok     = 1'b0;
    case (rx_state)
      RX_REARM: if (rx_sync) rx_next = RX_IDLE;
      RX_IDLE:  if (!rx_sync) begin
        rx_next = RX_START;
        rx_clr  = 1'b1;
      end
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_clr  = 1'b1;
        rx_next = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_clr      = 1'b1;
        rx_shift_en = 1'b1;
        if (rx_bit == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_clr = 1'b1;
        if (rx_sync) begin
          byte_ok = 1'b1;
          rx_next = RX_IDLE;
        end else begin
          rx_next = RX_REARM;
        end
      end
      default: rx_next = RX_REARM;
    endcase
  end

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      rx_state <= RX_REARM;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= (rx_clr || rx_state inside {RX_REARM, RX_IDLE}) ? '0 : rx_cnt + 1'b1;
      if (rx_shift_en) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  always_comb begin
    p_next = p_state;
    store  = 1'b0;
    commit = 1'b0;
    case (p_state)
      WAIT_R: if (byte_ok && rx_shift == 8'h72) p_next = DATA;
      DATA: if (byte_ok) begin
        store = 1'b1;
        if (p_idx == 3'd5) p_next = WAIT_T;
      end
      WAIT_T: if (byte_ok) begin
        p_next = WAIT_R;
        commit = (rx_shift == 8'h74);
      end
      default: p_next = WAIT_R;
    endcase
  end

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      p_state  <= WAIT_R;
      p_idx    <= '0;
      shadow   <= '0;
      time_reg <= '0;
      new_time <= 1'b0;
    end else begin
      p_state  <= p_next;
      new_time <= commit;
      if (p_state == WAIT_R) p_idx <= '0;
      else if (store)        p_idx <= p_idx + 1'b1;
      if (store)  shadow[3'd5 - p_idx] <= rx_shift;
      if (commit) time_reg <= shadow;
    end
  end

  // Transmitter: tx is registered from next-state values so the line changes
  // on the same edge as the state, with no combinational glitches.
  always_comb begin
    tx_next      = tx_state;
    tx_clr       = 1'b0;
    tx_load      = 1'b0;
    tx_adv       = 1'b0;
    tx_byte_done = 1'b0;
    case (tx_state)
      TX_IDLE: if (send_h_t) begin
        tx_next = TX_START;
        tx_load = 1'b1;
        tx_clr  = 1'b1;
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_clr  = 1'b1;
        tx_next = TX_DATA;
      end
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_clr = 1'b1;
        tx_adv = 1'b1;
        if (tx_bit == 3'd7) tx_next = TX_STOP;
      end
      TX_STOP: if (tx_cnt == BIT_LAST) begin
        tx_clr       = 1'b1;
        tx_byte_done = 1'b1;
        tx_next      = (tx_nb == 3'd5) ? TX_IDLE : TX_START;
      end
      default: tx_next = TX_IDLE;
    endcase
    tx_bit_n = tx_adv ? tx_bit + 1'b1 : tx_bit;
    tx_d     = 1'b1;
    case (tx_next)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_buf[5][tx_bit_n];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_nb    <= '0;
      tx_buf   <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx       <= tx_d;
      tx_cnt   <= (tx_clr || tx_state == TX_IDLE) ? '0 : tx_cnt + 1'b1;
      if (tx_adv) tx_bit <= tx_bit_n;
      if (tx_load) begin
        tx_buf <= {humidity, temperature};
        tx_nb  <= '0;
      end else if (tx_byte_done) begin
        tx_buf <= {tx_buf[4:0], 8'h00};
        tx_nb  <= tx_nb + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cntr.sv
// Directed bench for uart_cntr at a scaled bit period of 16 clocks.
module tb_uart_cntr;

  localparam int BIT = 16;

  logic            clk = 1'b0;
  logic            arstn;
  logic            rx;
  logic [2:0][7:0] humidity;
  logic [2:0][7:0] temperature;
  logic            send_h_t;
  logic [5:0][7:0] time_reg;
  logic            new_time;
  logic            tx;

  int checks = 0;
  int errors = 0;
  int nt_pulses = 0;
  int nt_high = 0;
  int exp_pulses = 0;
  logic nt_prev = 1'b0;

  uart_cntr #(.baudrate(10000), .clk_frec(160000)) dut (
    .clk(clk), .arstn(arstn), .rx(rx), .humidity(humidity),
    .temperature(temperature), .send_h_t(send_h_t), .time_reg(time_reg),
    .new_time(new_time), .tx(tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (new_time) nt_high++;
    if (new_time && !nt_prev) nt_pulses++;
    nt_prev <= new_time;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < 8; i++) send_rx(f[8*(7-i) +: 8], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_time(input string tag, input logic [47:0] exp);
    chk({tag, "_time_reg"}, time_reg, exp);
    chk({tag, "_pulses"}, nt_pulses, exp_pulses);
    chk({tag, "_high_cycles"}, nt_high, exp_pulses);
  endtask

  task automatic recv_byte(input int maxw, output logic [7:0] b);
    int w = 0;
    while (tx !== 1'b0 && w < maxw) begin
      @(negedge clk);
      w++;
    end
    chk("tx_start_edge", tx, 0);
    repeat (BIT / 2) @(negedge clk);
    chk("tx_start_mid", tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      b[i] = tx;
    end
    repeat (BIT) @(negedge clk);
    chk("tx_stop", tx, 1);
  endtask

  task automatic recv_seq(input logic [47:0] exp, input string tag);
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      recv_byte((i == 0) ? 2 : BIT / 2 + 1, b);
      chk($sformatf("%s_byte%0d", tag, i), b, exp[8*(5-i) +: 8]);
    end
  endtask

  task automatic pulse_send;
    @(negedge clk) send_h_t = 1'b1;
    @(negedge clk) send_h_t = 1'b0;
  endtask

  initial begin
    logic seen_low;
    arstn = 1'b1;
    rx = 1'b1;
    send_h_t = 1'b0;
    humidity = '0;
    temperature = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_new_time", new_time, 0);
    chk("reset_time_reg", time_reg, 0);
    arstn = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(64'h72_30_31_32_33_34_35_74);
    exp_pulses++;
    check_time("frame1", 48'h30_31_32_33_34_35);

    send_frame(64'h72_33_34_35_36_37_38_74);
    exp_pulses++;
    check_time("frame2", 48'h33_34_35_36_37_38);

    send_frame(64'h72_30_31_32_33_34_35_74);
    exp_pulses++;
    check_time("frame3", 48'h30_31_32_33_34_35);

    send_frame(64'h72_72_74_01_02_03_04_41);
    check_time("bad_term", 48'h30_31_32_33_34_35);

    send_frame(64'h72_72_74_55_AA_00_FF_74);
    exp_pulses++;
    check_time("rt_payload", 48'h72_74_55_AA_00_FF);

    send_rx(8'h72, 1'b1);
    send_rx(8'h99, 1'b0);
    for (int i = 0; i < 6; i++) send_rx(8'h10 + 8'(i), 1'b1);
    send_rx(8'h74, 1'b1);
    repeat (4) @(negedge clk);
    exp_pulses++;
    check_time("framing_err", 48'h10_11_12_13_14_15);

    send_rx(8'h72, 1'b1);
    for (int i = 0; i < 3; i++) send_rx(8'h40 + 8'(i), 1'b1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    for (int i = 3; i < 6; i++) send_rx(8'h40 + 8'(i), 1'b1);
    send_rx(8'h74, 1'b1);
    repeat (4) @(negedge clk);
    exp_pulses++;
    check_time("glitch", 48'h40_41_42_43_44_45);

    humidity = {8'd1, 8'd2, 8'd3};
    temperature = {8'd11, 8'd12, 8'd13};
    pulse_send();
    fork
      recv_seq(48'h01_02_03_0B_0C_0D, "tx1");
      begin
        repeat (BIT * 15) @(negedge clk);
        humidity = '1;
        temperature = '1;
        send_h_t = 1'b1;
        @(negedge clk) send_h_t = 1'b0;
      end
    join
    seen_low = 1'b0;
    repeat (3 * BIT) begin
      @(negedge clk);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    chk("tx_idle_after_ignored", seen_low, 0);

    humidity = {8'd21, 8'd22, 8'd23};
    temperature = {8'd31, 8'd32, 8'd33};
    pulse_send();
    recv_seq(48'h15_16_17_1F_20_21, "tx2");
    repeat (2 * BIT) @(negedge clk);

    humidity = {8'hA5, 8'h5A, 8'h00};
    temperature = {8'hFF, 8'h80, 8'h01};
    fork
      send_frame(64'h72_01_02_03_04_05_06_74);
      begin
        pulse_send();
        recv_seq(48'hA5_5A_00_FF_80_01, "tx3");
      end
    join
    exp_pulses++;
    check_time("concurrent", 48'h01_02_03_04_05_06);

    humidity = {8'd1, 8'd2, 8'd3};
    temperature = {8'd11, 8'd12, 8'd13};
    pulse_send();
    repeat (5) @(negedge clk);
    chk("tx_low_pre_reset", tx, 0);
    #1 arstn = 1'b1;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_time_reg", time_reg, 0);
    chk("async_reset_new_time", new_time, 0);
    @(negedge clk);
    @(negedge clk) arstn = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    chk("post_reset_tx_idle", tx, 1);
    pulse_send();
    recv_seq(48'h01_02_03_0B_0C_0D, "tx4");

    send_frame(64'h72_30_31_32_33_34_35_74);
    exp_pulses++;
    check_time("post_reset_frame", 48'h30_31_32_33_34_35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
